mem_wb: RTL and testbench

Memory-access and writeback stage of the RISC-V pipeline. Accepts one instruction at a time from the execute stage through a valid/ready handshake and performs any load or store against the data-memory port, including byte-lane steering, load alignment and sign/zero extension. Drives the register file write port (`wb_we`/`wb_waddr`/`wb_wdata`) with a registered, single-cycle writeback pulse. Raises a stall request to the pipeline controller while a memory transaction is outstanding.

---
 rtl/mem_wb_pkg.sv | 55 +++++
 rtl/mem_wb_if.sv | 24 ++
 rtl/mem_wb_load_align.sv | 34 +++
 rtl/mem_wb.sv | 154 +++++++++++++++
 tb/tb_mem_wb.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared widths, funct3 codes, FSM states and lane helpers for mem_wb
package mem_wb_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;

    // RV32I load/store width codes
    localparam logic [2:0] LB_F3  = 3'b000;
    localparam logic [2:0] LH_F3  = 3'b001;
    localparam logic [2:0] LW_F3  = 3'b010;
    localparam logic [2:0] LBU_F3 = 3'b100;
    localparam logic [2:0] LHU_F3 = 3'b101;
    localparam logic [2:0] SB_F3  = 3'b000;
    localparam logic [2:0] SH_F3  = 3'b001;
    localparam logic [2:0] SW_F3  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when funct3 names a defined width for the given direction.
    function automatic logic width_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return (f3 == LB_F3) || (f3 == LH_F3) || (f3 == LW_F3) ||
                   (f3 == LBU_F3) || (f3 == LHU_F3);
        else
            return (f3 == SB_F3) || (f3 == SH_F3) || (f3 == SW_F3);
    endfunction

    // funct3[1:0] encodes the size for both signed and unsigned loads.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the store value puts it on every lane; the strobes pick the live one.
    function automatic logic [REG_BUS-1:0] store_lanes(input logic [2:0] f3,
                                                       input logic [REG_BUS-1:0] sd);
        case (f3[1:0])
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_if.sv
// rtl/mem_wb_if.sv - data-memory request/response port
interface mem_wb_if;
    import mem_wb_pkg::*;

    logic                req;
    logic                gnt;
    logic [REG_BUS-1:0]  addr;
    logic                we;
    logic [3:0]          be;
    logic [REG_BUS-1:0]  wdata;
    logic                rvalid;
    logic [REG_BUS-1:0]  rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_wb_load_align.sv
// rtl/mem_wb_load_align.sv - selects and extends the loaded byte/halfword
module load_align
    import mem_wb_pkg::*;
(
    input  logic [REG_BUS-1:0] rdata,
    input  logic [1:0]         addr_lo,
    input  logic [2:0]         funct3,
    output logic [REG_BUS-1:0] result
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Lane selection followed by sign or zero extension.
    always_comb begin
        byte_val = rdata[7:0];
        case (addr_lo)
            2'd0: byte_val = rdata[7:0];
            2'd1: byte_val = rdata[15:8];
            2'd2: byte_val = rdata[23:16];
            2'd3: byte_val = rdata[31:24];
            default: byte_val = rdata[7:0];
        endcase
        half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB_F3:   result = {{24{byte_val[7]}}, byte_val};
            LBU_F3:  result = {24'd0, byte_val};
            LH_F3:   result = {{16{half_val[15]}}, half_val};
            LHU_F3:  result = {16'd0, half_val};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - memory-access and writeback pipeline stage
module mem_wb
    import mem_wb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    output logic                    ex_ready,
    input  logic                    ex_wd,
    input  logic [REG_ADDR_BUS-1:0] ex_waddr,
    input  logic [REG_BUS-1:0]      ex_wdata,
    input  logic                    ex_mem_re,
    input  logic                    ex_mem_we,
    input  logic [2:0]              ex_funct3,
    input  logic [REG_BUS-1:0]      ex_mem_addr,
    input  logic [REG_BUS-1:0]      ex_store_data,
    mem_wb_if.master                mem,
    input  logic                    flush,
    output logic                    wb_we,
    output logic [REG_ADDR_BUS-1:0] wb_waddr,
    output logic [REG_BUS-1:0]      wb_wdata,
    output logic                    stall_req,
    output logic                    mem_exc
);

    state_t state, state_next;

    logic                    lat_load;
    logic                    lat_wd;
    logic [REG_ADDR_BUS-1:0] lat_waddr;
    logic [2:0]              lat_f3;
    logic [REG_BUS-1:0]      lat_addr;
    logic [3:0]              lat_be;
    logic [REG_BUS-1:0]      lat_wdata;
    logic                    lat_flushed;

    logic                    is_mem;
    logic                    access_ok;
    logic                    in_req;
    logic [REG_BUS-1:0]      load_result;

    assign is_mem    = ex_mem_re || ex_mem_we;
    assign access_ok = width_legal(ex_mem_re, ex_funct3) &&
                       !misaligned(ex_funct3, ex_mem_addr[1:0]);

    load_align u_load_align (
        .rdata   (mem.rdata),
        .addr_lo (lat_addr[1:0]),
        .funct3  (lat_f3),
        .result  (load_result)
    );

    // State register; reset abandons any outstanding response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        ex_ready   = 1'b0;
        stall_req  = 1'b1;
        in_req     = 1'b0;
        case (state)
            ST_IDLE: begin
                ex_ready  = 1'b1;
                stall_req = 1'b0;
                if (ex_valid && !flush && is_mem && access_ok)
                    state_next = ST_REQ;
            end
            ST_REQ: begin
                in_req = 1'b1;
                if (mem.gnt)
                    state_next = lat_load ? ST_RESP : ST_IDLE;
                else if (flush)
                    state_next = ST_IDLE;
            end
            ST_RESP: begin
                if (mem.rvalid)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request fields come from the latched operation and read as zero outside REQ.
    assign mem.req   = in_req;
    assign mem.addr  = in_req ? {lat_addr[31:2], 2'b00} : '0;
    assign mem.we    = in_req && !lat_load;
    assign mem.be    = in_req ? lat_be : 4'b0000;
    assign mem.wdata = in_req ? lat_wdata : '0;

    // Operation latch, registered writeback pulse and exception pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_load    <= 1'b0;
            lat_wd      <= 1'b0;
            lat_waddr   <= '0;
            lat_f3      <= 3'b000;
            lat_addr    <= '0;
            lat_be      <= 4'b0000;
            lat_wdata   <= '0;
            lat_flushed <= 1'b0;
            wb_we       <= 1'b0;
            wb_waddr    <= '0;
            wb_wdata    <= '0;
            mem_exc     <= 1'b0;
        end else begin
            wb_we   <= 1'b0;
            mem_exc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ex_valid && !flush) begin
                        if (!is_mem) begin
                            wb_we    <= ex_wd && (ex_waddr != '0);
                            wb_waddr <= ex_waddr;
                            wb_wdata <= ex_wdata;
                        end else if (!access_ok) begin
                            mem_exc <= 1'b1;
                        end else begin
                            lat_load    <= ex_mem_re;
                            lat_wd      <= ex_wd && (ex_waddr != '0);
                            lat_waddr   <= ex_waddr;
                            lat_f3      <= ex_funct3;
                            lat_addr    <= ex_mem_addr;
                            lat_be      <= lane_be(ex_funct3, ex_mem_addr[1:0]);
                            lat_wdata   <= store_lanes(ex_funct3, ex_store_data);
                            lat_flushed <= 1'b0;
                        end
                    end
                end
                ST_REQ: begin
                    // A flush coinciding with the grant still owes us a response.
                    if (mem.gnt)
                        lat_flushed <= flush;
                end
                ST_RESP: begin
                    if (flush)
                        lat_flushed <= 1'b1;
                    if (mem.rvalid) begin
                        wb_we    <= lat_wd && !lat_flushed && !flush;
                        wb_waddr <= lat_waddr;
                        wb_wdata <= load_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb.sv
// tb/tb_mem_wb.sv - directed self-checking bench for mem_wb
module tb_mem_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_wd;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        ex_mem_re;
    logic        ex_mem_we;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        stall_req;
    logic        mem_exc;

    int errors = 0;
    int checks = 0;

    mem_wb_if mbus ();

    mem_wb dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_wd         (ex_wd),
        .ex_waddr      (ex_waddr),
        .ex_wdata      (ex_wdata),
        .ex_mem_re     (ex_mem_re),
        .ex_mem_we     (ex_mem_we),
        .ex_funct3     (ex_funct3),
        .ex_mem_addr   (ex_mem_addr),
        .ex_store_data (ex_store_data),
        .mem           (mbus),
        .flush         (flush),
        .wb_we         (wb_we),
        .wb_waddr      (wb_waddr),
        .wb_wdata      (wb_wdata),
        .stall_req     (stall_req),
        .mem_exc       (mem_exc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_wd = 0; ex_waddr = 0; ex_wdata = 0;
        ex_mem_re = 0; ex_mem_we = 0; ex_funct3 = 0;
        ex_mem_addr = 0; ex_store_data = 0;
    endtask

    task automatic present_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        ex_valid = 1; ex_wd = 1; ex_waddr = rd; ex_wdata = 32'h0;
        ex_mem_re = 1; ex_mem_we = 0; ex_funct3 = f3; ex_mem_addr = addr;
    endtask

    // LB/LBU style sequence: grant held off 3 cycles, rvalid two cycles after grant.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        present_load(f3, addr, 5'd7);
        step();
        idle_inputs();
        step(); step(); step();
        mbus.gnt = 1;
        step();
        mbus.gnt = 0;
        step();
        mbus.rvalid = 1; mbus.rdata = rdata;
        step();
        mbus.rvalid = 0; mbus.rdata = 0;
    endtask

    initial begin
        rst = 0;
        flush = 0;
        idle_inputs();
        mbus.gnt = 0; mbus.rvalid = 0; mbus.rdata = 0;
        step();
        chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mbus.req}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_mem_exc", {31'd0, mem_exc}, 32'd0);
        chk("rst_mem_we", {31'd0, mbus.we}, 32'd0);
        rst = 1;
        step();

        // ALU op writeback one cycle after acceptance, for one cycle only
        ex_valid = 1; ex_wd = 1; ex_waddr = 5; ex_wdata = 32'hDEADBEEF;
        step();
        idle_inputs();
        chk("alu_wb_we", {31'd0, wb_we}, 32'd1);
        chk("alu_wb_waddr", {27'd0, wb_waddr}, 32'd5);
        chk("alu_wb_wdata", wb_wdata, 32'hDEADBEEF);
        chk("alu_ex_ready", {31'd0, ex_ready}, 32'd1);
        step();
        chk("alu_wb_we_off", {31'd0, wb_we}, 32'd0);

        // Back-to-back ALU ops, second one targets x0
        ex_valid = 1; ex_wd = 1; ex_waddr = 3; ex_wdata = 32'h11;
        step();
        chk("b2b1_wb_we", {31'd0, wb_we}, 32'd1);
        chk("b2b1_wdata", wb_wdata, 32'h11);
        ex_waddr = 0; ex_wdata = 32'h22;
        step();
        idle_inputs();
        chk("b2b_x0_wb_we", {31'd0, wb_we}, 32'd0);

        // SB at 0x1003
        ex_valid = 1; ex_mem_we = 1; ex_funct3 = 3'b000;
        ex_mem_addr = 32'h1003; ex_store_data = 32'h000000A5;
        step();
        idle_inputs();
        chk("sb_req", {31'd0, mbus.req}, 32'd1);
        chk("sb_be", {28'd0, mbus.be}, 32'h8);
        chk("sb_wdata", mbus.wdata, 32'hA5A5A5A5);
        chk("sb_addr", mbus.addr, 32'h1000);
        chk("sb_we", {31'd0, mbus.we}, 32'd1);
        chk("sb_ex_ready", {31'd0, ex_ready}, 32'd0);
        chk("sb_stall", {31'd0, stall_req}, 32'd1);
        mbus.gnt = 1;
        step();
        mbus.gnt = 0;
        chk("sb_done_req", {31'd0, mbus.req}, 32'd0);
        chk("sb_done_ready", {31'd0, ex_ready}, 32'd1);
        chk("sb_no_wb", {31'd0, wb_we}, 32'd0);

        // SH at 0x1002
        ex_valid = 1; ex_mem_we = 1; ex_funct3 = 3'b001;
        ex_mem_addr = 32'h1002; ex_store_data = 32'h0000BEEF;
        step();
        idle_inputs();
        chk("sh_be", {28'd0, mbus.be}, 32'hC);
        chk("sh_wdata", mbus.wdata, 32'hBEEFBEEF);
        mbus.gnt = 1;
        step();
        mbus.gnt = 0;

        // LB at 0x2002: request fields held while grant is delayed
        present_load(3'b000, 32'h2002, 5'd7);
        step();
        idle_inputs();
        step(); step();
        chk("lb_req_held", {31'd0, mbus.req}, 32'd1);
        chk("lb_addr", mbus.addr, 32'h2000);
        chk("lb_be", {28'd0, mbus.be}, 32'h4);
        chk("lb_we", {31'd0, mbus.we}, 32'd0);
        step();
        mbus.gnt = 1;
        step();
        mbus.gnt = 0;
        chk("lb_resp_req", {31'd0, mbus.req}, 32'd0);
        chk("lb_resp_stall", {31'd0, stall_req}, 32'd1);
        step();
        chk("lb_wait_wb", {31'd0, wb_we}, 32'd0);
        mbus.rvalid = 1; mbus.rdata = 32'h0080FF00;
        step();
        mbus.rvalid = 0; mbus.rdata = 0;
        chk("lb_wb_we", {31'd0, wb_we}, 32'd1);
        chk("lb_wb_waddr", {27'd0, wb_waddr}, 32'd7);
        chk("lb_wb_wdata", wb_wdata, 32'hFFFFFF80);
        chk("lb_ready", {31'd0, ex_ready}, 32'd1);
        step();
        chk("lb_wb_off", {31'd0, wb_we}, 32'd0);

        run_load(3'b100, 32'h2002, 32'h0080FF00);
        chk("lbu_wb_we", {31'd0, wb_we}, 32'd1);
        chk("lbu_wb_wdata", wb_wdata, 32'h00000080);

        run_load(3'b001, 32'h2002, 32'h80010000);
        chk("lh_wb_wdata", wb_wdata, 32'hFFFF8001);

        run_load(3'b101, 32'h2000, 32'h12348765);
        chk("lhu_wb_wdata", wb_wdata, 32'h00008765);

        run_load(3'b010, 32'h2004, 32'hCAFEF00D);
        chk("lw_wb_wdata", wb_wdata, 32'hCAFEF00D);

        // Misaligned LW
        present_load(3'b010, 32'h3002, 5'd9);
        step();
        idle_inputs();
        chk("mis_exc", {31'd0, mem_exc}, 32'd1);
        chk("mis_req", {31'd0, mbus.req}, 32'd0);
        chk("mis_wb", {31'd0, wb_we}, 32'd0);
        chk("mis_ready", {31'd0, ex_ready}, 32'd1);
        step();
        chk("mis_exc_off", {31'd0, mem_exc}, 32'd0);
        chk("mis_req_off", {31'd0, mbus.req}, 32'd0);

        // Undefined store width
        ex_valid = 1; ex_mem_we = 1; ex_funct3 = 3'b100; ex_mem_addr = 32'h4000;
        step();
        idle_inputs();
        chk("undef_exc", {31'd0, mem_exc}, 32'd1);
        chk("undef_req", {31'd0, mbus.req}, 32'd0);

        // Flush in IDLE drops the incoming ALU op
        ex_valid = 1; ex_wd = 1; ex_waddr = 4; ex_wdata = 32'h55; flush = 1;
        step();
        idle_inputs(); flush = 0;
        chk("flush_idle_wb", {31'd0, wb_we}, 32'd0);

        // Flush in REQ before grant
        present_load(3'b010, 32'h5000, 5'd6);
        step();
        idle_inputs();
        flush = 1;
        step();
        flush = 0;
        chk("flush_req_req", {31'd0, mbus.req}, 32'd0);
        chk("flush_req_ready", {31'd0, ex_ready}, 32'd1);

        // LH granted, flush during RESP, rvalid 4 cycles later
        present_load(3'b001, 32'h2000, 5'd8);
        step();
        idle_inputs();
        mbus.gnt = 1;
        step();
        mbus.gnt = 0;
        flush = 1;
        step();
        flush = 0;
        step(); step();
        chk("flush_resp_waiting", {31'd0, ex_ready}, 32'd0);
        step();
        mbus.rvalid = 1; mbus.rdata = 32'h00001234;
        step();
        mbus.rvalid = 0; mbus.rdata = 0;
        chk("flush_resp_wb", {31'd0, wb_we}, 32'd0);
        chk("flush_resp_ready", {31'd0, ex_ready}, 32'd1);

        // Reset while in RESP, then a stray rvalid
        present_load(3'b010, 32'h6000, 5'd10);
        step();
        idle_inputs();
        mbus.gnt = 1;
        step();
        mbus.gnt = 0;
        chk("pre_rst_stall", {31'd0, stall_req}, 32'd1);
        rst = 0;
        #1;
        chk("arst_stall", {31'd0, stall_req}, 32'd0);
        chk("arst_ready", {31'd0, ex_ready}, 32'd1);
        chk("arst_req", {31'd0, mbus.req}, 32'd0);
        chk("arst_wb_we", {31'd0, wb_we}, 32'd0);
        step();
        rst = 1;
        mbus.rvalid = 1; mbus.rdata = 32'hFFFFFFFF;
        step();
        mbus.rvalid = 0;
        chk("stray_rvalid_wb", {31'd0, wb_we}, 32'd0);
        chk("stray_rvalid_ready", {31'd0, ex_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
